gpio_in_filter: RTL and testbench

- Parametrised multi-channel input conditioner for board-level digital inputs: user switches, joystick, selection switches, microSD detect and spare header inputs.
- Per channel it provides:
  - SyncStages-flop synchroniser
  - optional polarity inversion
  - tick-based debounce filter
  - single-cycle rise/fall pulses
  - sticky event flags with a maskable interrupt
- Sits between top-level pins and the system GPIO block. It supersedes ad-hoc inversion and unfiltered switch sampling at top level.

---
 rtl/gpio_in_filter_pkg.sv | 12 +
 rtl/gpio_in_filter_chan.sv | 132 +++++++++++++
 rtl/gpio_in_filter.sv | 53 +++++
 tb/tb_gpio_in_filter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_in_filter_pkg.sv
// Shared types and constants for the gpio_in_filter input conditioner.
package gpio_in_filter_pkg;

  typedef enum logic [1:0] {
    FiltStable    = 2'd0,
    FiltCandidate = 2'd1,
    FiltCommit    = 2'd2
  } filt_state_e;

  localparam int BounceCntWidth = 8;

endpackage

// File: rtl/gpio_in_filter_chan.sv
// One input channel: synchroniser, polarity fix, tick debounce FSM, edge pulses,
// sticky event flag and (with GPIO_IN_FILTER_BOUNCE_CNT_EN) a rejected-glitch counter.
module gpio_in_filter_chan
  import gpio_in_filter_pkg::*;
#(
  parameter int   SyncStages = 2,
  parameter int   CntWidth   = 16,
  parameter logic Invert     = 1'b1,
  parameter logic ResetLevel = 1'b0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      pin_i,
  input  logic                      en_i,
  input  logic                      tick_i,
  input  logic [CntWidth-1:0]       thresh_i,
  input  logic                      clear_i,
  output logic                      level_o,
  output logic                      rise_o,
  output logic                      fall_o,
  output logic                      event_o,
  output logic [BounceCntWidth-1:0] bounce_cnt_o
);

  logic [SyncStages-1:0] sync_q;
  logic                  raw;
  filt_state_e           state_q, state_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic                  level_q, level_d;
  logic                  event_q;
  logic                  reject;

  // Reset value matches the idle pin level so no edge appears on reset release.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= {SyncStages{ResetLevel ^ Invert}};
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], pin_i};
    end
  end

  assign raw = sync_q[SyncStages-1] ^ Invert;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= FiltStable;
      cnt_q   <= '0;
      level_q <= ResetLevel;
      event_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      event_q <= (event_q & ~clear_i) | rise_o | fall_o;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    reject  = 1'b0;
    if (!en_i) begin
      state_d = FiltStable;
      cnt_d   = '0;
    end else begin
      case (state_q)
        FiltStable: begin
          cnt_d = '0;
          if (raw != level_q) begin
            // A zero threshold bypasses the filter and commits straight away.
            if (thresh_i == '0) begin
              state_d = FiltCommit;
              level_d = raw;
            end else begin
              state_d = FiltCandidate;
            end
          end
        end
        FiltCandidate: begin
          if (raw == level_q) begin
            state_d = FiltStable;
            cnt_d   = '0;
            reject  = 1'b1;
          end else if (cnt_q >= thresh_i) begin
            state_d = FiltCommit;
            level_d = raw;
            cnt_d   = '0;
          end else if (tick_i) begin
            // Here cnt_q < thresh_i, so the increment cannot wrap.
            cnt_d = cnt_q + CntWidth'(1);
          end
        end
        FiltCommit: begin
          state_d = FiltStable;
          cnt_d   = '0;
        end
        default: begin
          state_d = FiltStable;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // The level register flips on entry to FiltCommit, so pulses line up with it.
  assign rise_o  = (state_q == FiltCommit) & level_q;
  assign fall_o  = (state_q == FiltCommit) & ~level_q;
  assign level_o = level_q;
  assign event_o = event_q;

`ifdef GPIO_IN_FILTER_BOUNCE_CNT_EN
  logic [BounceCntWidth-1:0] bounce_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bounce_q <= '0;
    end else if (clear_i) begin
      bounce_q <= reject ? BounceCntWidth'(1) : '0;
    end else if (reject && (bounce_q != '1)) begin
      bounce_q <= bounce_q + BounceCntWidth'(1);
    end
  end

  assign bounce_cnt_o = bounce_q;
`else
  logic unused_reject;
  assign unused_reject = reject;
  assign bounce_cnt_o  = '0;
`endif

endmodule

// File: rtl/gpio_in_filter.sv
// Multi-channel debounced GPIO input conditioner with sticky events and a maskable irq.
// Optional rejected-glitch counters are built when GPIO_IN_FILTER_BOUNCE_CNT_EN is defined.
module gpio_in_filter
  import gpio_in_filter_pkg::*;
#(
  parameter int                     NumChannels = 16,
  parameter int                     SyncStages  = 2,
  parameter int                     CntWidth    = 16,
  parameter logic [NumChannels-1:0] InvertMask  = {NumChannels{1'b1}},
  parameter logic [NumChannels-1:0] ResetLevel  = {NumChannels{1'b0}}
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NumChannels-1:0]                pins_i,
  input  logic [NumChannels-1:0]                chan_en_i,
  input  logic                                  tick_i,
  input  logic [CntWidth-1:0]                   debounce_thresh_i,
  input  logic [NumChannels-1:0]                event_clear_i,
  input  logic [NumChannels-1:0]                irq_mask_i,
  output logic [NumChannels-1:0]                level_o,
  output logic [NumChannels-1:0]                rise_o,
  output logic [NumChannels-1:0]                fall_o,
  output logic [NumChannels-1:0]                event_o,
  output logic                                  irq_o,
  output logic [BounceCntWidth*NumChannels-1:0] bounce_cnt_o
);

  for (genvar i = 0; i < NumChannels; i++) begin : g_chan
    gpio_in_filter_chan #(
      .SyncStages (SyncStages),
      .CntWidth   (CntWidth),
      .Invert     (InvertMask[i]),
      .ResetLevel (ResetLevel[i])
    ) u_chan (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .pin_i        (pins_i[i]),
      .en_i         (chan_en_i[i]),
      .tick_i       (tick_i),
      .thresh_i     (debounce_thresh_i),
      .clear_i      (event_clear_i[i]),
      .level_o      (level_o[i]),
      .rise_o       (rise_o[i]),
      .fall_o       (fall_o[i]),
      .event_o      (event_o[i]),
      .bounce_cnt_o (bounce_cnt_o[BounceCntWidth*i +: BounceCntWidth])
    );
  end

  // Both operands are registered or static, so the OR tree cannot glitch.
  assign irq_o = |(event_o & irq_mask_i);

endmodule

// File: tb/tb_gpio_in_filter.sv
// Bench for gpio_in_filter: directed stimulus, expected edge pulses queued and
// checked by an independent negedge monitor, plus direct level/event/irq checks.
module tb_gpio_in_filter;

  localparam int N  = 4;
  localparam int S  = 2;
  localparam int CW = 16;
`ifdef GPIO_IN_FILTER_BOUNCE_CNT_EN
  localparam logic [7:0] ExpGlitchCnt = 8'd1;
`else
  localparam logic [7:0] ExpGlitchCnt = 8'd0;
`endif

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [N-1:0]  pins, chan_en, event_clear, irq_mask;
  logic          tick;
  logic [CW-1:0] thresh;
  logic [N-1:0]  level, rise, fall, evt;
  logic          irq;
  logic [8*N-1:0] bounce_cnt;

  gpio_in_filter #(
    .NumChannels (N),
    .SyncStages  (S),
    .CntWidth    (CW),
    .InvertMask  (4'b1111),
    .ResetLevel  (4'b0000)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .pins_i            (pins),
    .chan_en_i         (chan_en),
    .tick_i            (tick),
    .debounce_thresh_i (thresh),
    .event_clear_i     (event_clear),
    .irq_mask_i        (irq_mask),
    .level_o           (level),
    .rise_o            (rise),
    .fall_o            (fall),
    .event_o           (evt),
    .irq_o             (irq),
    .bounce_cnt_o      (bounce_cnt)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // tick_period: 0 = no ticks, 1 = every cycle, k = every k-th cycle
  int tick_period = 0;
  initial begin
    tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tick = (tick_period == 1) || (tick_period > 1 && (cyc % tick_period) == 0);
    end
  end

  // scoreboard: entry = {cycle[15:0], channel[1:0], is_rise}
  logic [18:0] exp_q[$];
  logic [18:0] mon_e;
  int n_checks   = 0;
  int n_fail     = 0;
  int pulse_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_pulse(input int at, input int ch, input logic is_rise);
    exp_q.push_back({at[15:0], ch[1:0], is_rise});
  endtask

  // monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (exp_q.size() > 0) begin
        mon_e = exp_q[0];
        if (int'(mon_e[18:3]) < cyc) begin
          check("pulse_missed", 32'(cyc[15:0]), 32'(mon_e[18:3]));
          void'(exp_q.pop_front());
        end
      end
      for (int ch = 0; ch < N; ch++) begin
        if (rise[ch] || fall[ch]) begin
          pulse_seen++;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_pulse: ch %0d rise %0b fall %0b, expected none (cycle %0d)",
                     ch, rise[ch], fall[ch], cyc);
          end else begin
            mon_e = exp_q.pop_front();
            check("pulse", 32'({cyc[15:0], ch[1:0], rise[ch]}), 32'(mon_e));
            check("pulse_level", 32'(level[ch]), 32'(rise[ch]));
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1; pins = '1; chan_en = '1; event_clear = '0; irq_mask = '0;
    thresh = 16'd3; tick_period = 0;
    step(3);
    check("rst_level", 32'(level), 32'h0);
    check("rst_pulses", 32'(rise | fall), 32'h0);
    check("rst_event", 32'(evt), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_bounce", bounce_cnt, 32'h0);
    rst = 1'b0;

    // reset release with inactive pins: nothing moves
    step(100);
    check("idle_level", 32'(level), 32'h0);
    check("idle_irq", 32'(irq), 32'h0);
    check("idle_pulses", pulse_seen, 0);

    // debounce press on ch0, thresh 3, tick every cycle
    tick_period = 1; irq_mask = 4'b0001;
    pins[0] = 1'b0;
    expect_pulse(cyc + S + 5, 0, 1'b1);
    step(10);
    check("press_level0", 32'(level[0]), 32'h1);
    check("press_event0", 32'(evt[0]), 32'h1);
    check("press_irq", 32'(irq), 32'h1);

    // clear in the same cycle as the fall pulse: set wins
    pins[0] = 1'b1;
    expect_pulse(cyc + S + 5, 0, 1'b0);
    step(S + 5);
    event_clear = 4'b0001;
    step(1);
    event_clear = '0;
    check("setwins_event0", 32'(evt[0]), 32'h1);
    check("setwins_level0", 32'(level[0]), 32'h0);
    event_clear = 4'b0001;
    step(1);
    event_clear = '0;
    check("clear_event0", 32'(evt[0]), 32'h0);
    check("clear_irq", 32'(irq), 32'h0);

    // glitch on ch1 shorter than the threshold
    thresh = 16'd10; tick_period = 4;
    pins[1] = 1'b0;
    step(8);
    pins[1] = 1'b1;
    step(15);
    check("glitch_level1", 32'(level[1]), 32'h0);
    check("glitch_event1", 32'(evt[1]), 32'h0);
    check("glitch_cnt1", 32'(bounce_cnt[15:8]), 32'(ExpGlitchCnt));
    event_clear = 4'b0010;
    step(1);
    event_clear = '0;
    check("glitch_cnt1_clr", 32'(bounce_cnt[15:8]), 32'h0);

    // bypass on ch2: level tracks with S+1 lag, one pulse per toggle
    thresh = '0;
    for (int k = 0; k < 6; k++) begin
      pins[2] = ~pins[2];
      expect_pulse(cyc + S + 1, 2, pins[2] == 1'b0);
      step(3);
    end
    step(5);
    check("bypass_level2", 32'(level[2]), 32'h0);

    // disable mid-candidate on ch3, then re-enable: full count again
    thresh = 16'd4; tick_period = 1;
    pins[3] = 1'b0;
    step(5);
    chan_en[3] = 1'b0;
    step(5);
    check("disabled_level3", 32'(level[3]), 32'h0);
    chan_en[3] = 1'b1;
    expect_pulse(cyc + 4 + 2, 3, 1'b1);
    step(10);
    check("reenable_level3", 32'(level[3]), 32'h1);

    // threshold lowered 20 -> 2 once the count reaches 5
    thresh = 16'd20;
    pins[3] = 1'b1;
    step(S + 6);
    thresh = 16'd2;
    expect_pulse(cyc + 1, 3, 1'b0);
    step(5);
    check("lowthr_level3", 32'(level[3]), 32'h0);

    // reset while ch0 is high and ch1 is mid-candidate
    thresh = 16'd3;
    pins[0] = 1'b0;
    expect_pulse(cyc + S + 5, 0, 1'b1);
    step(10);
    check("prerst_level0", 32'(level[0]), 32'h1);
    thresh = 16'd10;
    pins[1] = 1'b0;
    step(6);
    rst = 1'b1;
    pins = '1;
    step(2);
    rst = 1'b0;
    step(12);
    check("postrst_level", 32'(level), 32'h0);
    check("postrst_event", 32'(evt), 32'h0);
    check("postrst_irq", 32'(irq), 32'h0);
    check("postrst_bounce", bounce_cnt, 32'h0);

    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
